// File: rtl/count_req_arb_pkg.sv
// Shared types and constants for the counter request arbiter.
package count_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_e;

   localparam logic OP_INC  = 1'b0;
   localparam logic OP_LOAD = 1'b1;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_NCORES = 4;

endpackage

// File: rtl/count_req_arb_if.sv
// Core-request bus plus counter strobe bus seen by the arbiter.
interface count_req_arb_if #(
   parameter int NCORES = 4,
   parameter int WIDTH  = 16
);

   logic [NCORES-1:0]       req;
   logic [NCORES-1:0]       op;
   logic [NCORES*WIDTH-1:0] wdata;
   logic [NCORES-1:0]       ack;
   logic [WIDTH-1:0]        rdata;
   logic [WIDTH-1:0]        q_in;
   logic                    load;
   logic                    inc;
   logic [WIDTH-1:0]        d;

   modport master (
      input  req, op, wdata, q_in,
      output ack, rdata, load, inc, d
   );

   modport slave (
      output req, op, wdata, q_in,
      input  ack, rdata, load, inc, d
   );

endinterface

// File: rtl/count_req_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_pick #(
   parameter int NCORES = 4,
   parameter int IDXW   = $clog2(NCORES)
) (
   input  logic [NCORES-1:0] req,
   input  logic [IDXW-1:0]   ptr,
   output logic              valid,
   output logic [IDXW-1:0]   index
);

   logic [IDXW-1:0] j;

   always_comb begin
      valid = 1'b0;
      index = '0;
      j     = '0;
      for (int unsigned k = 0; k < NCORES; k++) begin
         j = IDXW'((32'(ptr) + k) % NCORES);
         if (!valid && req[j]) begin
            valid = 1'b1;
            index = j;
         end
      end
   end

endmodule

// File: rtl/count_req_arb.sv
// Serializes per-core increment/load requests onto a shared counter and
// acknowledges each with the post-update counter value.
module count_req_arb
   import count_pkg::*;
#(
   parameter int NCORES = DEF_NCORES,
   parameter int WIDTH  = DEF_WIDTH
) (
   input logic             CLK,
   input logic             RST,
   count_req_arb_if.master bus
);

   localparam int IDXW = $clog2(NCORES);
   localparam logic [IDXW-1:0] LAST = IDXW'(NCORES - 1);

   state_e            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   gidx_q, gidx_d;
   logic              load_q, load_d;
   logic              inc_q, inc_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic [NCORES-1:0] ack_q, ack_d;

   logic              pick_valid;
   logic [IDXW-1:0]   pick_idx;

   rr_pick #(.NCORES(NCORES), .IDXW(IDXW)) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // The load/inc/d registers double as the latched op and data for the grant.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      load_d  = 1'b0;
      inc_d   = 1'b0;
      d_d     = '0;
      ack_d   = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gidx_d = pick_idx;
               if (bus.op[pick_idx] == OP_LOAD) begin
                  load_d = 1'b1;
                  d_d    = bus.wdata[32'(pick_idx)*WIDTH +: WIDTH];
               end else begin
                  inc_d = 1'b1;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ack_d[gidx_q] = 1'b1;
            state_d       = RESP;
         end
         RESP: begin
            ptr_d   = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         load_q  <= 1'b0;
         inc_q   <= 1'b0;
         d_q     <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         load_q  <= load_d;
         inc_q   <= inc_d;
         d_q     <= d_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.ack  = ack_q;
   assign bus.load = load_q;
   assign bus.inc  = inc_q;
   assign bus.d    = d_q;
   // q_in is the counter's own register, so this gate stays register-to-output.
   assign bus.rdata = (state_q == RESP) ? bus.q_in : '0;

endmodule
